// File: rtl/vga_axil_if.sv
// ----------------------------------------------------------------------------
// vga_axil_if
//   AXI-Lite bus bundle between an interconnect master and the VGA register
//   block.
//   Parameters : ADDR_W (address width), DATA_W (data width, wstrb = DATA_W/8)
//   Modports   : master - drives AW/W/AR payload+valid, B/R ready
//                slave  - drives AW/W/AR ready, B/R response+valid
// ----------------------------------------------------------------------------
interface vga_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;

  modport master (
    output s_awaddr, s_awvalid, input s_awready,
    output s_wdata, s_wstrb, s_wvalid, input s_wready,
    input  s_bresp, s_bvalid, output s_bready,
    output s_araddr, s_arvalid, input s_arready,
    input  s_rdata, s_rresp, s_rvalid, output s_rready
  );

  modport slave (
    input  s_awaddr, s_awvalid, output s_awready,
    input  s_wdata, s_wstrb, s_wvalid, output s_wready,
    output s_bresp, s_bvalid, input s_bready,
    input  s_araddr, s_arvalid, output s_arready,
    output s_rdata, s_rresp, s_rvalid, input s_rready
  );
endinterface

// File: rtl/vga_axil_regs.sv
// ----------------------------------------------------------------------------
// vga_axil_regs
//   AXI-Lite slave register file for the VGA timing/pixel core. One
//   outstanding transaction per channel; read and write paths independent.
//   Register map (addr[3:2]; any set address bit above [3] -> SLVERR):
//     0x0 CTRL       RW  [0] enable, [1] test pattern, [2] irq enable
//     0x4 BG_COLOR   RW  [BG_COLOR_W-1:0]
//     0x8 FRAME_CNT  RO  frames completed while enabled (write -> SLVERR)
//     0xC IRQ_STATUS W1C [0] frame pending
//   Optional feature macro: VGA_AXIL_REGS_IRQ_EN
//     defined   : IRQ_STATUS and CTRL[2] implemented, irq_o port present
//     undefined : no irq_o, CTRL[2] reads 0, 0xC is unmapped (SLVERR)
// Ports
//   clk          system clock, posedge
//   arst_n       asynchronous active-low reset
//   s_axil       AXI-Lite slave (vga_axil_if.slave)
//   frame_done_i one-cycle end-of-frame pulse from the VGA core
//   enable_o     CTRL[0]
//   test_pat_o   CTRL[1]
//   bg_color_o   BG_COLOR register
//   irq_o        registered frame interrupt (feature build only)
// ----------------------------------------------------------------------------
module vga_axil_regs #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int BG_COLOR_W  = 12
) (
  input  logic                  clk,
  input  logic                  arst_n,
  vga_axil_if.slave             s_axil,
  input  logic                  frame_done_i,
  output logic                  enable_o,
  output logic                  test_pat_o,
  output logic [BG_COLOR_W-1:0] bg_color_o
`ifdef VGA_AXIL_REGS_IRQ_EN
  ,
  output logic                  irq_o
`endif
);

  localparam int STRB_W = AXIL_DATA_W / 8;
`ifdef VGA_AXIL_REGS_IRQ_EN
  localparam int CTRL_W  = 3;
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam int CTRL_W  = 2;
  localparam bit HAS_IRQ = 1'b0;
`endif
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] IDX_CTRL    = 2'd0;
  localparam logic [1:0] IDX_BG      = 2'd1;
  localparam logic [1:0] IDX_FCNT    = 2'd2;
  localparam logic [1:0] IDX_IRQ     = 2'd3;

  // Decide whether an access hits a legal register for its direction.
  function automatic logic addr_ok(input logic [AXIL_ADDR_W-1:0] addr, input logic is_write);
    logic ok;
    if (addr[AXIL_ADDR_W-1:4] != '0) begin
      ok = 1'b0;
    end else begin
      case (addr[3:2])
        IDX_CTRL: ok = 1'b1;
        IDX_BG:   ok = 1'b1;
        IDX_FCNT: ok = !is_write;
        IDX_IRQ:  ok = HAS_IRQ;
        default:  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Replace only the byte lanes enabled by the strobe.
  function automatic logic [AXIL_DATA_W-1:0] byte_merge(
    input logic [AXIL_DATA_W-1:0] old_v,
    input logic [AXIL_DATA_W-1:0] new_v,
    input logic [STRB_W-1:0]      strb
  );
    logic [AXIL_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Write channel state
  logic                   awready_q, awready_d;
  logic                   aw_cap_q, aw_cap_d;
  logic [AXIL_ADDR_W-1:0] awaddr_q, awaddr_d;
  logic                   wready_q, wready_d;
  logic                   w_cap_q, w_cap_d;
  logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]      wstrb_q, wstrb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  // Read channel state
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  // Register file
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
  logic [BG_COLOR_W-1:0]  bg_q, bg_d;
  logic [31:0]            frame_cnt_q, frame_cnt_d;

  logic                   wr_fire_s;
  logic                   wr_ok_s;
  logic [1:0]             wr_idx_s;
  logic [AXIL_DATA_W-1:0] wr_old_s;
  logic [AXIL_DATA_W-1:0] wr_merged_s;
  logic                   w1c_s;
  logic                   ar_hs_s;
  logic [1:0]             rd_idx_s;
  logic [AXIL_DATA_W-1:0] rd_val_s;
  logic                   frame_tick_s;
  logic                   unused_ok_s;

`ifdef VGA_AXIL_REGS_IRQ_EN
  logic                   irq_pend_q, irq_pend_d;
  logic                   irq_q, irq_d;
`endif

  // A write commits one cycle after both AW and W are held and no response is pending.
  assign wr_fire_s    = aw_cap_q & w_cap_q & ~bvalid_q;
  assign wr_idx_s     = awaddr_q[3:2];
  assign wr_ok_s      = addr_ok(awaddr_q, 1'b1);
  assign wr_merged_s  = byte_merge(wr_old_s, wdata_q, wstrb_q);
  assign w1c_s        = wr_fire_s & wr_ok_s & (wr_idx_s == IDX_IRQ) & wstrb_q[0] & wdata_q[0];
  assign ar_hs_s      = s_axil.s_arvalid & arready_q;
  assign rd_idx_s     = s_axil.s_araddr[3:2];
  assign frame_tick_s = frame_done_i & ctrl_q[0];
  assign unused_ok_s  = ^{awaddr_q[1:0], s_axil.s_araddr[1:0],
                          wr_merged_s[AXIL_DATA_W-1:BG_COLOR_W]};

  // Current value of the register targeted by the pending write (merge base).
  always_comb begin
    wr_old_s = '0;
    case (wr_idx_s)
      IDX_CTRL: wr_old_s = AXIL_DATA_W'(ctrl_q);
      IDX_BG:   wr_old_s = AXIL_DATA_W'(bg_q);
      default:  wr_old_s = '0;
    endcase
  end

  // Write channel handshake sequencing and response generation.
  always_comb begin
    aw_cap_d = aw_cap_q;
    awaddr_d = awaddr_q;
    w_cap_d  = w_cap_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s_axil.s_bready) begin
      aw_cap_d = 1'b0;
      w_cap_d  = 1'b0;
      bvalid_d = 1'b0;
    end else if (wr_fire_s) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (s_axil.s_awvalid && awready_q) begin
        aw_cap_d = 1'b1;
        awaddr_d = s_axil.s_awaddr;
      end else begin
        aw_cap_d = aw_cap_q;
      end
      if (s_axil.s_wvalid && wready_q) begin
        w_cap_d = 1'b1;
        wdata_d = s_axil.s_wdata;
        wstrb_d = s_axil.s_wstrb;
      end else begin
        w_cap_d = w_cap_q;
      end
    end
    awready_d = ~aw_cap_d & ~bvalid_d;
    wready_d  = ~w_cap_d & ~bvalid_d;
  end

  // Register file updates from committed writes.
  always_comb begin
    ctrl_d = ctrl_q;
    bg_d   = bg_q;
    if (wr_fire_s && wr_ok_s) begin
      case (wr_idx_s)
        IDX_CTRL: ctrl_d = wr_merged_s[CTRL_W-1:0];
        IDX_BG:   bg_d   = wr_merged_s[BG_COLOR_W-1:0];
        default:  ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Frame counter: disabling the core restarts the count; otherwise count ticks.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (ctrl_q[0] && !ctrl_d[0]) begin
      frame_cnt_d = 32'd0;
    end else if (frame_tick_s) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Read data mux over the register file (pre-update values).
  always_comb begin
    rd_val_s = '0;
    case (rd_idx_s)
      IDX_CTRL: rd_val_s = AXIL_DATA_W'(ctrl_q);
      IDX_BG:   rd_val_s = AXIL_DATA_W'(bg_q);
      IDX_FCNT: rd_val_s = AXIL_DATA_W'(frame_cnt_q);
`ifdef VGA_AXIL_REGS_IRQ_EN
      IDX_IRQ:  rd_val_s = AXIL_DATA_W'(irq_pend_q);
`endif
      default:  rd_val_s = '0;
    endcase
  end

  // Read channel: capture response on AR handshake, hold until accepted.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      if (addr_ok(s_axil.s_araddr, 1'b0)) begin
        rdata_d = rd_val_s;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end else if (rvalid_q && s_axil.s_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
    arready_d = ~rvalid_d;
  end

  // State registers for both channels and the register file.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      awready_q   <= 1'b0;
      aw_cap_q    <= 1'b0;
      awaddr_q    <= '0;
      wready_q    <= 1'b0;
      w_cap_q     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      ctrl_q      <= '0;
      bg_q        <= '0;
      frame_cnt_q <= 32'd0;
    end else begin
      awready_q   <= awready_d;
      aw_cap_q    <= aw_cap_d;
      awaddr_q    <= awaddr_d;
      wready_q    <= wready_d;
      w_cap_q     <= w_cap_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      ctrl_q      <= ctrl_d;
      bg_q        <= bg_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef VGA_AXIL_REGS_IRQ_EN
  // Pending flag: a new frame event beats a simultaneous clear.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (frame_tick_s) begin
      irq_pend_d = 1'b1;
    end else if (w1c_s) begin
      irq_pend_d = 1'b0;
    end else begin
      irq_pend_d = irq_pend_q;
    end
    irq_d = irq_pend_d & ctrl_d[2];
  end

  // Interrupt state registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

  assign s_axil.s_awready = awready_q;
  assign s_axil.s_wready  = wready_q;
  assign s_axil.s_bvalid  = bvalid_q;
  assign s_axil.s_bresp   = bresp_q;
  assign s_axil.s_arready = arready_q;
  assign s_axil.s_rvalid  = rvalid_q;
  assign s_axil.s_rdata   = rdata_q;
  assign s_axil.s_rresp   = rresp_q;
  assign enable_o         = ctrl_q[0];
  assign test_pat_o       = ctrl_q[1];
  assign bg_color_o       = bg_q;

endmodule

// File: tb/tb_vga_axil_regs.sv
// ----------------------------------------------------------------------------
// tb_vga_axil_regs
//   Self-checking bench for vga_axil_regs: directed scenarios followed by
//   randomized AXI-Lite traffic and frame pulses, checked against a
//   register-level reference model.
// ----------------------------------------------------------------------------
module tb_vga_axil_regs;
  localparam int TMO = 40;
`ifdef VGA_AXIL_REGS_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk;
  logic        arst_n;
  logic        frame_done_i;
  logic        enable_o;
  logic        test_pat_o;
  logic [11:0] bg_color_o;
`ifdef VGA_AXIL_REGS_IRQ_EN
  logic        irq_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [2:0]  m_ctrl;
  logic [11:0] m_bg;
  logic [31:0] m_cnt;
  logic        m_pend;

  vga_axil_if #(.ADDR_W(32), .DATA_W(32)) axil ();

  vga_axil_regs #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32), .BG_COLOR_W(12)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .s_axil       (axil.slave),
    .frame_done_i (frame_done_i),
    .enable_o     (enable_o),
    .test_pat_o   (test_pat_o),
    .bg_color_o   (bg_color_o)
`ifdef VGA_AXIL_REGS_IRQ_EN
    ,
    .irq_o        (irq_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] mask;
    logic [31:0] nv;
    mask = 32'd0;
    for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hFF << (8 * i));
    if (addr[31:4] != 28'd0) return 2'b10;
    case (addr[3:2])
      2'd0: begin
        nv = ({29'd0, m_ctrl} & ~mask) | (data & mask);
        nv = nv & (IRQ ? 32'h7 : 32'h3);
        if (m_ctrl[0] && !nv[0]) m_cnt = 32'd0;
        m_ctrl = nv[2:0];
        return 2'b00;
      end
      2'd1: begin
        nv = ({20'd0, m_bg} & ~mask) | (data & mask);
        m_bg = nv[11:0];
        return 2'b00;
      end
      2'd2: return 2'b10;
      default: begin
        if (!IRQ) return 2'b10;
        if (strb[0] && data[0]) m_pend = 1'b0;
        return 2'b00;
      end
    endcase
  endfunction

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    data = 32'd0;
    resp = 2'b00;
    if (addr[31:4] != 28'd0) resp = 2'b10;
    else if (addr[3:2] == 2'd0) data = {29'd0, m_ctrl};
    else if (addr[3:2] == 2'd1) data = {20'd0, m_bg};
    else if (addr[3:2] == 2'd2) data = m_cnt;
    else if (IRQ) data = {31'd0, m_pend};
    else resp = 2'b10;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_enable"}, {31'd0, enable_o}, {31'd0, m_ctrl[0]});
    check_eq({tag, "_test_pat"}, {31'd0, test_pat_o}, {31'd0, m_ctrl[1]});
    check_eq({tag, "_bg_color"}, {20'd0, bg_color_o}, {20'd0, m_bg});
`ifdef VGA_AXIL_REGS_IRQ_EN
    check_eq({tag, "_irq"}, {31'd0, irq_o}, {31'd0, m_pend & m_ctrl[2]});
`endif
  endtask

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] exp_resp, input string tag);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int cyc     = 0;
    axil.s_awaddr = addr;
    axil.s_wdata  = data;
    axil.s_wstrb  = strb;
    while (!(aw_done && w_done) && cyc < TMO) begin
      @(negedge clk);
      axil.s_awvalid = !aw_done && (cyc >= aw_dly);
      axil.s_wvalid  = !w_done && (cyc >= w_dly);
      if (axil.s_awvalid && axil.s_awready) aw_done = 1'b1;
      if (axil.s_wvalid && axil.s_wready) w_done = 1'b1;
      cyc++;
    end
    @(negedge clk);
    axil.s_awvalid = 1'b0;
    axil.s_wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check_eq({tag, "_aw_w_timeout"}, 32'd0, 32'd1);
      return;
    end
    cyc = 0;
    while (!axil.s_bvalid && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_bvalid"}, {31'd0, axil.s_bvalid}, 32'd1);
    check_eq({tag, "_bresp"}, {30'd0, axil.s_bresp}, {30'd0, exp_resp});
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check_eq({tag, "_bvalid_hold"}, {31'd0, axil.s_bvalid}, 32'd1);
      check_eq({tag, "_bresp_hold"}, {30'd0, axil.s_bresp}, {30'd0, exp_resp});
      check_eq({tag, "_awready_hold"}, {31'd0, axil.s_awready}, 32'd0);
    end
    axil.s_bready = 1'b1;
    @(negedge clk);
    axil.s_bready = 1'b0;
    check_eq({tag, "_bvalid_drop"}, {31'd0, axil.s_bvalid}, 32'd0);
    check_eq({tag, "_awready_back"}, {31'd0, axil.s_awready}, 32'd1);
  endtask

  task automatic axil_read(input logic [31:0] addr, input int r_dly,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp, input string tag);
    bit done = 1'b0;
    int cyc  = 0;
    axil.s_araddr = addr;
    while (!done && cyc < TMO) begin
      @(negedge clk);
      axil.s_arvalid = 1'b1;
      if (axil.s_arready) done = 1'b1;
      cyc++;
    end
    @(negedge clk);
    axil.s_arvalid = 1'b0;
    if (!done) begin
      check_eq({tag, "_ar_timeout"}, 32'd0, 32'd1);
      return;
    end
    check_eq({tag, "_rvalid"}, {31'd0, axil.s_rvalid}, 32'd1);
    check_eq({tag, "_rdata"}, axil.s_rdata, exp_data);
    check_eq({tag, "_rresp"}, {30'd0, axil.s_rresp}, {30'd0, exp_resp});
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check_eq({tag, "_rvalid_hold"}, {31'd0, axil.s_rvalid}, 32'd1);
      check_eq({tag, "_rdata_hold"}, axil.s_rdata, exp_data);
      check_eq({tag, "_arready_hold"}, {31'd0, axil.s_arready}, 32'd0);
    end
    axil.s_rready = 1'b1;
    @(negedge clk);
    axil.s_rready = 1'b0;
    check_eq({tag, "_rvalid_drop"}, {31'd0, axil.s_rvalid}, 32'd0);
    check_eq({tag, "_arready_back"}, {31'd0, axil.s_arready}, 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input string tag);
    logic [1:0] exp_resp;
    exp_resp = model_write(addr, data, strb);
    axil_write(addr, data, strb, aw_dly, w_dly, b_dly, exp_resp, tag);
    check_outputs(tag);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly, input string tag);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    model_read(addr, exp_data, exp_resp);
    axil_read(addr, r_dly, exp_data, exp_resp, tag);
  endtask

  task automatic frame_pulse(input string tag);
    @(negedge clk);
    frame_done_i = 1'b1;
    @(negedge clk);
    frame_done_i = 1'b0;
    if (m_ctrl[0]) begin
      m_cnt = m_cnt + 32'd1;
      if (IRQ) m_pend = 1'b1;
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] addr_tbl [7];
    logic [31:0] addr;
    addr_tbl = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'h8000_0000};
    m_ctrl = 3'd0; m_bg = 12'd0; m_cnt = 32'd0; m_pend = 1'b0;
    arst_n = 1'b1; frame_done_i = 1'b0;
    axil.s_awaddr = 32'd0; axil.s_awvalid = 1'b0; axil.s_wdata = 32'd0; axil.s_wstrb = 4'd0;
    axil.s_wvalid = 1'b0; axil.s_bready = 1'b0; axil.s_araddr = 32'd0; axil.s_arvalid = 1'b0;
    axil.s_rready = 1'b0;
    #2 arst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_awready", {31'd0, axil.s_awready}, 32'd0);
    check_eq("rst_wready", {31'd0, axil.s_wready}, 32'd0);
    check_eq("rst_arready", {31'd0, axil.s_arready}, 32'd0);
    check_eq("rst_bvalid", {31'd0, axil.s_bvalid}, 32'd0);
    check_eq("rst_rvalid", {31'd0, axil.s_rvalid}, 32'd0);
    check_eq("rst_bresp", {30'd0, axil.s_bresp}, 32'd0);
    check_eq("rst_rresp", {30'd0, axil.s_rresp}, 32'd0);
    check_eq("rst_rdata", axil.s_rdata, 32'd0);
    check_outputs("rst");
    arst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_arready", {31'd0, axil.s_arready}, 32'd1);
    check_eq("post_rst_awready", {31'd0, axil.s_awready}, 32'd1);

    // CTRL write with AW leading W by two cycles
    do_write(32'h0, 32'h3, 4'hF, 0, 2, 0, "ctrl_wr");
    check_eq("ctrl_enable_on", {31'd0, enable_o}, 32'd1);
    check_eq("ctrl_tpat_on", {31'd0, test_pat_o}, 32'd1);
    // byte-lane strobe on BG_COLOR
    do_write(32'h4, 32'hABC, 4'h1, 1, 0, 0, "bg_wr");
    check_eq("bg_lane0", {20'd0, bg_color_o}, 32'h0BC);
    do_read(32'h4, 0, "bg_rd");
    // frame counting
    for (int i = 0; i < 5; i++) frame_pulse("fc_pulse");
    do_read(32'h8, 0, "fc5_rd");
    // counter wrap from a preloaded all-ones value
    @(negedge clk);
    force dut.frame_cnt_d = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_cnt_d;
    m_cnt = 32'hFFFF_FFFF;
    do_read(32'h8, 0, "fc_max_rd");
    frame_pulse("fc_wrap_pulse");
    do_read(32'h8, 0, "fc_wrap_rd");
    frame_pulse("fc_pulse2");
    frame_pulse("fc_pulse3");
    // error responses leave state untouched
    do_read(32'h10, 0, "oor_rd");
    do_write(32'h8, 32'h55, 4'hF, 0, 0, 0, "fc_wr_err");
    do_read(32'h8, 0, "fc_after_err_rd");
    // back-pressure on both response channels
    do_read(32'h4, 10, "rhold_rd");
    do_write(32'h4, 32'h123, 4'h3, 0, 0, 10, "bhold_wr");
    // interrupt path (SLVERR path in the base build)
    do_write(32'h0, 32'h5, 4'hF, 0, 0, 0, "irq_ctrl_wr");
    frame_pulse("irq_pulse");
    do_read(32'hC, 0, "irq_st_rd");
    do_write(32'hC, 32'h1, 4'h1, 0, 0, 0, "irq_w1c");
    do_read(32'h0, 0, "ctrl_rd");
    // disable clears the counter
    do_write(32'h0, 32'h0, 4'h1, 2, 0, 1, "disable_wr");
    do_read(32'h8, 0, "fc_cleared_rd");

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      addr = addr_tbl[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0, 1: do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), "rnd_wr");
        2, 3: do_read(addr, $urandom_range(0, 3), "rnd_rd");
        default: begin
          for (int k = 0; k < $urandom_range(1, 3); k++) frame_pulse("rnd_pulse");
        end
      endcase
    end
    do_read(32'h8, 0, "final_fc_rd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
